// File: rtl/fcore_wide_prefetcher.sv
// Wide-word instruction prefetcher: latches LDC immediates and blanks until the channel sweep ends.
// Optional statistics counters are built only when FCORE_PREFETCH_STATS_EN is defined.
package fcore_isa;
  localparam int unsigned LDC = 12;
  localparam int unsigned EFI = 14;
endpackage

module fcore_wide_prefetcher #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int OPCODE_WIDTH      = 5,
  parameter int MAX_CHANNELS      = 255,
  parameter int LOAD_WORDS        = 2,
  localparam int CW               = $clog2(MAX_CHANNELS)
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      run,
  input  logic                                      stall,
  input  logic [(1+LOAD_WORDS)*INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic [CW-1:0]                             channel_address_in,
  input  logic [CW-1:0]                             n_channels,
  output logic [INSTRUCTION_WIDTH-1:0]              instruction_out,
  output logic [LOAD_WORDS*INSTRUCTION_WIDTH-1:0]   load_data,
  output logic [CW-1:0]                             channel_address_out,
  output logic                                      immediate_advance,
  output logic                                      efi_call,
  output logic                                      blanking,
  output logic [15:0]                               ldc_count,
  output logic [15:0]                               efi_count
);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_BLANK = 1'b1;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDC = OPCODE_WIDTH'(fcore_isa::LDC);
  localparam logic [OPCODE_WIDTH-1:0] OP_EFI = OPCODE_WIDTH'(fcore_isa::EFI);
  localparam int IW = INSTRUCTION_WIDTH;

  logic [0:0]                   state_q, state_d;
  logic [IW-1:0]                instr_q, instr_d;
  logic [LOAD_WORDS*IW-1:0]     load_q, load_d;
  logic [CW-1:0]                chan_q;
  logic [IW-1:0]                word0;
  logic [LOAD_WORDS*IW-1:0]     imm;
  logic [OPCODE_WIDTH-1:0]      opcode;
  logic [CW-1:0]                term_cnt;
  logic                         is_ldc, is_efi, tc_exit;

  assign word0    = instruction_in[IW-1:0];
  assign imm      = instruction_in[(1+LOAD_WORDS)*IW-1:IW];
  assign opcode   = word0[OPCODE_WIDTH-1:0];
  assign is_ldc   = (opcode == OP_LDC);
  assign is_efi   = (opcode == OP_EFI);
  // Zero or one active channel both collapse to a single-cycle blank on channel 0.
  assign term_cnt = (n_channels <= CW'(1)) ? '0 : n_channels - CW'(1);
  assign tc_exit  = (state_q == S_BLANK) && (channel_address_in == term_cnt);

  assign immediate_advance = is_ldc && (state_q == S_RUN) && !stall;
  assign efi_call          = is_efi && !stall;
  assign blanking          = (state_q == S_BLANK);
  assign instruction_out   = instr_q;
  assign load_data         = load_q;
  assign channel_address_out = chan_q;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    load_d  = load_q;
    if (tc_exit) begin
      state_d = S_RUN;
      instr_d = word0;
    end else if (state_q == S_RUN) begin
      instr_d = word0;
      if (is_ldc) begin
        state_d = S_BLANK;
        load_d  = imm;
      end
    end else if (run) begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      instr_q <= '0;
      load_q  <= '0;
      chan_q  <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      chan_q  <= channel_address_in;
    end
  end

`ifdef FCORE_PREFETCH_STATS_EN
  logic [15:0] ldc_cnt_q, efi_cnt_q;

  // A run pulse clears the counters outright, even if an LDC/EFI lands in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || (run && !stall)) begin
      ldc_cnt_q <= '0;
      efi_cnt_q <= '0;
    end else begin
      if (immediate_advance && (ldc_cnt_q != 16'hFFFF)) ldc_cnt_q <= ldc_cnt_q + 16'd1;
      if (efi_call && (efi_cnt_q != 16'hFFFF))          efi_cnt_q <= efi_cnt_q + 16'd1;
    end
  end

  assign ldc_count = ldc_cnt_q;
  assign efi_count = efi_cnt_q;
`else
  assign ldc_count = '0;
  assign efi_count = '0;
`endif
endmodule

// File: tb/tb_fcore_wide_prefetcher.sv
// Scoreboard bench: driver pushes per-cycle expectations from a reference model, a negedge monitor compares.
module tb_fcore_wide_prefetcher;
  localparam int IW = 16;
  localparam int LW = 2;
  localparam int CW = 8;
  localparam logic [4:0] LDC5 = 5'(fcore_isa::LDC);
  localparam logic [4:0] EFI5 = 5'(fcore_isa::EFI);

  logic clock = 1'b0;
  logic reset, run, stall;
  logic [(1+LW)*IW-1:0] instruction_in;
  logic [CW-1:0] channel_address_in, n_channels;
  logic [IW-1:0] instruction_out;
  logic [LW*IW-1:0] load_data;
  logic [CW-1:0] channel_address_out;
  logic immediate_advance, efi_call, blanking;
  logic [15:0] ldc_count, efi_count;

  always #5 clock = ~clock;

  fcore_wide_prefetcher dut (
    .clock(clock), .reset(reset), .run(run), .stall(stall),
    .instruction_in(instruction_in), .channel_address_in(channel_address_in),
    .n_channels(n_channels), .instruction_out(instruction_out), .load_data(load_data),
    .channel_address_out(channel_address_out), .immediate_advance(immediate_advance),
    .efi_call(efi_call), .blanking(blanking), .ldc_count(ldc_count), .efi_count(efi_count)
  );

  typedef struct {
    logic ia, ef, blank;
    logic [IW-1:0] ins;
    logic [LW*IW-1:0] ld;
    logic [CW-1:0] ch;
    logic [15:0] lc, ec;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state: what the registered outputs hold right now.
  bit            m_blank = 0;
  logic [IW-1:0] m_ins = '0;
  logic [LW*IW-1:0] m_ld = '0;
  logic [CW-1:0] m_ch = '0;
  int            m_lc = 0, m_ec = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit ru, input bit st, input logic [IW-1:0] w0,
                     input logic [IW-1:0] w1, input logic [IW-1:0] w2,
                     input logic [CW-1:0] ch, input logic [CW-1:0] n);
    exp_t e;
    int tc;
    bit op_ldc, op_efi;
    @(posedge clock); #1;
    reset = r; run = ru; stall = st;
    instruction_in = {w2, w1, w0};
    channel_address_in = ch; n_channels = n;
    op_ldc = (w0[4:0] == LDC5);
    op_efi = (w0[4:0] == EFI5);
    e.ia = op_ldc && !m_blank && !st;
    e.ef = op_efi && !st;
    e.blank = m_blank; e.ins = m_ins; e.ld = m_ld; e.ch = m_ch;
`ifdef FCORE_PREFETCH_STATS_EN
    e.lc = 16'(m_lc); e.ec = 16'(m_ec);
`else
    e.lc = 16'd0; e.ec = 16'd0;
`endif
    q.push_back(e);
    tc = (int'(n) < 2) ? 0 : int'(n) - 1;
    if (r) begin
      m_blank = 0; m_ins = '0; m_ld = '0; m_ch = '0; m_lc = 0; m_ec = 0;
    end else if (!st) begin
      if (m_blank && int'(ch) == tc) begin
        m_blank = 0; m_ins = w0;
      end else if (!m_blank) begin
        m_ins = w0;
        if (op_ldc) begin m_blank = 1; m_ld = {w2, w1}; end
      end else if (ru) begin
        m_blank = 0;
      end
      m_ch = ch;
      if (ru) begin m_lc = 0; m_ec = 0; end
      else begin
        if (e.ia && m_lc < 16'hFFFF) m_lc++;
        if (e.ef && m_ec < 16'hFFFF) m_ec++;
      end
    end
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("immediate_advance", immediate_advance, e.ia);
      chk("efi_call", efi_call, e.ef);
      chk("blanking", blanking, e.blank);
      chk("instruction_out", instruction_out, e.ins);
      chk("load_data", load_data, e.ld);
      chk("channel_address_out", channel_address_out, e.ch);
      chk("ldc_count", ldc_count, e.lc);
      chk("efi_count", efi_count, e.ec);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] ldc, w;
    logic [CW-1:0] n, ch;
    int r;
    ldc = 16'(fcore_isa::LDC);
    reset = 1; run = 0; stall = 0; instruction_in = '0;
    channel_address_in = '0; n_channels = 8'd4;
    cyc(1, 0, 0, 16'h0000, 0, 0, 0, 4);
    chk("reset_blanking", blanking, 0);
    chk("reset_instr", instruction_out, 0);
    // plain op, LDC, ignored LDC in BLANK, terminal-count exit
    cyc(0, 0, 0, 16'h0023, 0, 0, 0, 4);
    chk("plain_ia", immediate_advance, 0);
    cyc(0, 0, 0, ldc, 16'hDEAD, 16'hBEEF, 1, 4);
    chk("plain_instr", instruction_out, 16'h0023);
    chk("ldc_ia", immediate_advance, 1);
    cyc(0, 0, 0, ldc, 16'h2222, 16'h1111, 2, 4);
    chk("ldc_load", load_data, 32'hBEEFDEAD);
    chk("ldc_blank", blanking, 1);
    chk("blank_ia", immediate_advance, 0);
    cyc(0, 0, 0, 16'h0041, 0, 0, 3, 4);
    chk("blank_hold", blanking, 1);
    chk("blank_ignored_ldc", load_data, 32'hBEEFDEAD);
    cyc(0, 0, 0, 16'h0023, 0, 0, 0, 4);
    chk("exit_blank", blanking, 0);
    chk("exit_instr", instruction_out, 16'h0041);
    // single channel: one-cycle blank
    cyc(0, 0, 0, ldc, 16'h4444, 16'h3333, 0, 1);
    cyc(0, 0, 0, 16'h0045, 0, 0, 0, 1);
    chk("n1_blank", blanking, 1);
    cyc(0, 0, 0, 16'h0023, 0, 0, 0, 1);
    chk("n1_exit", blanking, 0);
    chk("n1_instr", instruction_out, 16'h0045);
    // stall mid-BLANK
    cyc(0, 0, 0, ldc, 16'h5555, 16'h6666, 0, 4);
    cyc(0, 0, 0, 16'h0023, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, ldc, 16'h7777, 16'h8888, 3, 4);
      chk("stall_ia", immediate_advance, 0);
    end
    chk("stall_blank", blanking, 1);
    chk("stall_chan", channel_address_out, 1);
    chk("stall_load", load_data, 32'h66665555);
    cyc(0, 0, 0, 16'h0050, 0, 0, 3, 4);
    cyc(0, 0, 0, 16'h0023, 0, 0, 0, 4);
    chk("stall_exit", blanking, 0);
    // reset mid-BLANK
    cyc(0, 0, 0, ldc, 16'h9999, 16'hAAAA, 1, 4);
    cyc(1, 0, 0, ldc, 16'h1234, 16'h5678, 2, 4);
    cyc(0, 0, 0, 16'h0023, 0, 0, 3, 4);
    chk("rst_blank", blanking, 0);
    chk("rst_instr", instruction_out, 0);
    chk("rst_load", load_data, 0);
    chk("rst_ldc_count", ldc_count, 0);
    // randomized traffic
    n = 8'd4; ch = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) n = 8'($urandom_range(0, 6));
      ch = (int'(ch) + 1 >= ((int'(n) < 2) ? 1 : int'(n))) ? '0 : ch + 8'd1;
      if ($urandom_range(0, 19) == 0) ch = 8'($urandom_range(0, 7));
      w = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3) w[4:0] = LDC5;
      else if (r < 5) w[4:0] = EFI5;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          w, 16'($urandom), 16'($urandom), ch, n);
    end
    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fcore_wide_prefetcher.md
FCORE_WIDE_PREFETCHER -- requirements
Module: fcore_wide_prefetcher

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, width of one instruction word.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 5, opcode field in bits [OPCODE_WIDTH-1:0] of word 0.
REQ-003 SHALL have parameter MAX_CHANNELS, default 255; CW = $clog2(MAX_CHANNELS).
REQ-004 SHALL have parameter LOAD_WORDS, default 2, legal 1..3, immediate words carried by LDC.
REQ-005 SHALL have port clock, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port run, input, 1, program-start pulse; aborts any blanking.
REQ-008 SHALL have port stall, input, 1, freezes all registered state when high.
REQ-009 SHALL have port instruction_in, input, (1+LOAD_WORDS)*INSTRUCTION_WIDTH; word 0 at LSBs, immediates in words 1..LOAD_WORDS.
REQ-010 SHALL have port channel_address_in, input, CW, current channel.
REQ-011 SHALL have port n_channels, input, CW, active channel count.
REQ-012 SHALL have port instruction_out, output, INSTRUCTION_WIDTH, registered instruction.
REQ-013 SHALL have port load_data, output, LOAD_WORDS*INSTRUCTION_WIDTH, registered LDC immediate; word 1 at LSBs.
REQ-014 SHALL have port channel_address_out, output, CW, channel_address_in delayed one cycle.
REQ-015 SHALL have port immediate_advance, output, 1, combinational request to skip LOAD_WORDS extra program words.
REQ-016 SHALL have port efi_call, output, 1, combinational EFI opcode detect.
REQ-017 SHALL have port blanking, output, 1, high while state is BLANK.
REQ-018 SHALL have ports ldc_count and efi_count, outputs, 16 each, statistics counters (see Configuration).

Function
REQ-019 SHALL implement FSM with states RUN and BLANK, one-hot or binary, registered.
REQ-020 SHALL drive immediate_advance = (opcode==fcore_isa::LDC) & state==RUN & ~stall.
REQ-021 SHALL drive efi_call = (opcode==fcore_isa::EFI) & ~stall, regardless of state.
REQ-022 SHALL, in RUN without stall and opcode==LDC, register instruction_out<=word 0, load_data<=words 1..LOAD_WORDS, go to BLANK next cycle.
REQ-023 SHALL, in RUN without stall and opcode!=LDC, register instruction_out<=word 0, load_data unchanged.
REQ-024 SHALL, in BLANK, hold instruction_out and load_data, ignoring LDC opcodes (no new load, no immediate_advance).
REQ-025 SHALL leave BLANK to RUN in the cycle channel_address_in == n_channels-1, registering instruction_out<=word 0 that cycle.
REQ-026 SHALL treat n_channels of 0 or 1 as terminal count 0, so BLANK lasts exactly one cycle when channel_address_in==0.
REQ-027 SHALL, on run high (not stalled), force state RUN unless same-cycle RUN+LDC applies; priority: terminal-count exit > LDC entry > run.
REQ-028 SHALL register channel_address_out every non-stalled cycle; latency one cycle for all registered outputs.
REQ-029 SHALL, while stall high, hold state, instruction_out, load_data, channel_address_out and counters.

Reset
REQ-030 SHALL, on reset, set state RUN, instruction_out 0, load_data 0, channel_address_out 0, counters 0; reset overrides stall and run.
REQ-031 SHALL accept reset mid-BLANK and resume RUN on the next cycle with no pending load.

Configuration
REQ-032 SHALL compile statistics counters only when macro FCORE_PREFETCH_STATS_EN is defined.
REQ-033 SHALL, with FCORE_PREFETCH_STATS_EN, increment ldc_count on each accepted LDC and efi_count on each efi_call cycle, saturating at 16'hFFFF, cleared by run or reset.
REQ-034 SHALL, without FCORE_PREFETCH_STATS_EN, tie ldc_count and efi_count to 0 with no counter logic.

Verification
REQ-035 SHALL test plain op: word0=16'h0023 (non-LDC), n_channels=4 -> instruction_out=16'h0023 next cycle, immediate_advance 0.
REQ-036 SHALL test LDC, LOAD_WORDS=2: words {16'hBEEF,16'hDEAD,LDC} -> immediate_advance 1 same cycle, load_data=32'hBEEFDEAD next cycle, blanking 1.
REQ-037 SHALL test blanking exit: n_channels=4, channel 0..3 after LDC -> blanking stays 1 until channel 3 cycle, then 0; second LDC during BLANK ignored.
REQ-038 SHALL test n_channels=1: LDC then channel 0 -> BLANK lasts one cycle.
REQ-039 SHALL test stall=1 for 3 cycles mid-BLANK -> all outputs frozen, immediate_advance 0, exit resumes after stall drops.
REQ-040 SHALL test reset asserted in BLANK -> next cycle blanking 0, outputs 0, ldc_count 0 (with FCORE_PREFETCH_STATS_EN).
